aes_vlog_module: RTL and testbench
==================================

// Module: aes_vlog_module
// PURPOSE
//  APB-style register wrapper around an iterative AES-128 decryption core (CBC capable).
//  Software writes key, ciphertext and IV, pulses start, polls status, then reads plaintext.
//  Sits on the peripheral bus as a coprocessor; plaintext is also exported as a debug bus.
// PARAMETERS
//  CORE_MAX_LAT  64  max cycles from core load to core done (status timeout bound for benches)
// PORTS
//  vclk              in   1    clock, all state on rising edge
//  vrst              in   1    reset, asynchronous, active-low
//  vpsel             in   8    slave select; accepted, not used in decode
//  vpenable          in   1    access strobe; qualifies writes
//  vpaddr            in   32   byte address; only [7:2] decoded
//  vpwrite           in   1    1=write, 0=read
//  vpwdata           in   32   write data
//  vprdata           out  32   read data, combinational from vpaddr[7:2]
//  text_out_decrypt  out  128  current plaintext result register
// BEHAVIOUR
//  Reset (vrst=0, async): key/data/IV/result/ctrl/status = 0; core idle; vprdata follows decode (0).
//  Write: on vclk rise when vpenable&&vpwrite, reg at vpaddr[7:2] <= vpwdata. Unmapped: ignored.
//  Read: vprdata = reg at vpaddr[7:2], no wait states; unmapped -> 32'h0.
//  Map (word index; lowest index = bits [127:96]):
//   0x04-0x07 KEY (rw)   0x0C-0x0F DATA_IN ciphertext (rw)   0x14-0x17 IV (rw)
//   0x1C-0x1F DATA_OUT plaintext (ro)   0x20 CTRL (rw)   0x21 STATUS (ro)
//  CTRL bit1 START: writing 1 while idle launches one block; self-clears next cycle. Other bits rsvd, read 0.
//  STATUS bit0 DONE (sticky, cleared by next START), bit1 BUSY; others 0.
//  FSM IDLE -> LOAD (1 cyc: latch KEY/DATA_IN/IV into core operands, pulse core ld)
//   -> RUN (wait core done) -> FINISH (1 cyc: DATA_OUT <= core_out ^ IV_latched; DONE=1; BUSY=0) -> IDLE.
//  Chaining: in FINISH, IV <= DATA_IN_latched (ciphertext) so consecutive blocks form CBC.
//  START while BUSY: ignored. Register writes during BUSY: stored, do not affect in-flight block.
//  Software IV write in same cycle as FINISH chaining update: software write wins.
//  Reset mid-operation: block aborted, all state cleared, DONE=0.
//  text_out_decrypt == DATA_OUT at all times.
// CONFIGURATION
//  AES_CBC_EN defined: XOR with latched IV and IV chaining as above.
//  AES_CBC_EN undefined: ECB; DATA_OUT = core_out, IV reg stays r/w but is unused and never updated.
// STRUCTURE
//  Package aes_vlog_pkg: word-index localparams for each register, CTRL_START_BIT=1,
//   STAT_DONE_BIT=0, STAT_BUSY_BIT=1, FSM state enum (IDLE, LOAD, RUN, FINISH).
//  One sub-module aes_dec_core: AES-128 inverse cipher with internal key expansion;
//   ports clk, rst_n, ld, key[127:0], text_in[127:0], done (1-cyc pulse), text_out[127:0].
// TESTING
//  Reset: assert vrst low mid-run -> STATUS=0, DATA_OUT=0, text_out_decrypt=0.
//  FIPS-197: KEY=000102030405060708090a0b0c0d0e0f, DATA_IN=69c4e0d86a7b0430d8cdb78070b4c55a,
//   IV=0, CTRL=2 -> BUSY then DONE within CORE_MAX_LAT+3 cycles; DATA_OUT=00112233445566778899aabbccddeeff.
//  Chaining (AES_CBC_EN): repeat same DATA_IN, START -> DATA_OUT=69d5c2eb2e2e624750541d3bbc692ba5,
//   IV reads 69c4e0d86a7b0430d8cdb78070b4c55a.
//  ECB build (no AES_CBC_EN): both blocks above -> 00112233445566778899aabbccddeeff.
//  START while BUSY -> no restart, single DONE; write KEY mid-run -> result unchanged.
//  Unmapped read (index 0x00, 0x3F) -> 0; unmapped write -> no register changes.

Source files
------------

// File: rtl/aes_vlog_pkg.sv
// Shared register map, status/control bit positions and FSM encodings for the AES
// decryption coprocessor.
package aes_vlog_pkg;

    localparam int unsigned CORE_MAX_LAT = 64;

    // Word indices (vpaddr[7:2]); each 128-bit register spans four consecutive words
    localparam logic [5:0] KEY_IDX  = 6'h04;
    localparam logic [5:0] DIN_IDX  = 6'h0C;
    localparam logic [5:0] IV_IDX   = 6'h14;
    localparam logic [5:0] DOUT_IDX = 6'h1C;
    localparam logic [5:0] CTRL_IDX = 6'h20;
    localparam logic [5:0] STAT_IDX = 6'h21;

    localparam int CTRL_START_BIT = 1;
    localparam int STAT_DONE_BIT  = 0;
    localparam int STAT_BUSY_BIT  = 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    // Word 0 is the most significant 32 bits
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] w);
        return v[{~w, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/aes_vlog_if.sv
// Peripheral bus bundle between a bus master and the AES decryption coprocessor.
interface aes_vlog_if;
    logic [7:0]  vpsel;
    logic        vpenable;
    logic [31:0] vpaddr;
    logic        vpwrite;
    logic [31:0] vpwdata;
    logic [31:0] vprdata;

    modport master (
        output vpsel, vpenable, vpaddr, vpwrite, vpwdata,
        input  vprdata
    );

    modport slave (
        input  vpsel, vpenable, vpaddr, vpwrite, vpwdata,
        output vprdata
    );
endinterface

// File: rtl/aes_dec_core.sv
// Iterative AES-128 inverse cipher: expands the key forward to the last round key, then runs
// ten decryption rounds while unwinding the key schedule one step per round.
module aes_dec_core
    import aes_vlog_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [127:0] key,
    input  logic [127:0] text_in,
    output logic         done,
    output logic [127:0] text_out
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_EXP  = 2'd1;
    localparam logic [1:0] C_ADD  = 2'd2;
    localparam logic [1:0] C_RND  = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h01;
        t = gf_mul(a, a);
        for (int i = 0; i < 7; i++) begin
            r = gf_mul(r, t);
            t = gf_mul(t, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ key_g(k[31:0], rc);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ key_g(p3, rc);
        return {p0, p1, p2, p3};
    endfunction

    // Byte 4*c+r (row r, column c) sits at bits [127-8*(4*c+r) -: 8]
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    logic [1:0]   mode_q;
    logic [3:0]   round_q;
    logic [127:0] key_q;
    logic [127:0] state_q;
    logic         done_q;
    logic [127:0] key_fwd;
    logic [127:0] key_inv;
    logic [127:0] last_out;
    logic [127:0] round_out;

    always_comb begin
        key_fwd   = fwd_key(key_q, rcon_of(round_q));
        key_inv   = inv_key(key_q, rcon_of(round_q));
        last_out  = inv_shift_sub(state_q) ^ key_q;
        round_out = inv_mix_cols(last_out);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= C_IDLE;
            round_q <= 4'd0;
            key_q   <= '0;
            state_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ld) begin
                key_q   <= key;
                state_q <= text_in;
                round_q <= 4'd1;
                mode_q  <= C_EXP;
            end else begin
                case (mode_q)
                    C_EXP: begin
                        key_q <= key_fwd;
                        if (round_q == 4'd10) mode_q <= C_ADD;
                        else                  round_q <= round_q + 4'd1;
                    end
                    C_ADD: begin
                        state_q <= state_q ^ key_q;
                        key_q   <= key_inv;
                        round_q <= 4'd9;
                        mode_q  <= C_RND;
                    end
                    C_RND: begin
                        if (round_q != 4'd0) begin
                            state_q <= round_out;
                            key_q   <= key_inv;
                            round_q <= round_q - 4'd1;
                        end else begin
                            state_q <= last_out;
                            done_q  <= 1'b1;
                            mode_q  <= C_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign done     = done_q;
    assign text_out = state_q;

endmodule

// File: rtl/aes_vlog_module.sv
// Bus register wrapper around aes_dec_core. Define AES_CBC_EN for CBC (IV XOR and IV
// chaining); otherwise blocks are decrypted independently (ECB).
module aes_vlog_module
    import aes_vlog_pkg::*;
(
    input  logic         vclk,
    input  logic         vrst,
    aes_vlog_if.slave    bus,
    output logic [127:0] text_out_decrypt
);

    logic [5:0]   idx;
    logic [1:0]   widx;
    logic         wr_en;
    logic         key_hit, din_hit, iv_hit, dout_hit;
    logic         start_wr;
    logic [127:0] key_q, key_d;
    logic [127:0] din_q, din_d;
    logic [127:0] iv_q, iv_d;
    logic [127:0] dout_q;
    logic [127:0] plain;
    logic [1:0]   fsm_q, fsm_d;
    logic         start_q, busy_q, done_q;
    logic         core_ld, core_done;
    logic [127:0] core_out;
    logic [31:0]  rdata;
    logic         unused_bus;

    assign idx        = bus.vpaddr[7:2];
    assign widx       = idx[1:0];
    assign wr_en      = bus.vpenable && bus.vpwrite;
    assign key_hit    = idx[5:2] == KEY_IDX[5:2];
    assign din_hit    = idx[5:2] == DIN_IDX[5:2];
    assign iv_hit     = idx[5:2] == IV_IDX[5:2];
    assign dout_hit   = idx[5:2] == DOUT_IDX[5:2];
    assign start_wr   = wr_en && (idx == CTRL_IDX) && bus.vpwdata[CTRL_START_BIT] && !busy_q;
    assign unused_bus = ^{bus.vpsel, bus.vpaddr[31:8], bus.vpaddr[1:0]};

`ifdef AES_CBC_EN
    logic [127:0] din_lat_q;
    logic [127:0] iv_lat_q;

    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            din_lat_q <= '0;
            iv_lat_q  <= '0;
        end else if (fsm_q == LOAD) begin
            din_lat_q <= din_q;
            iv_lat_q  <= iv_q;
        end
    end

    assign plain = core_out ^ iv_lat_q;
`else
    assign plain = core_out;
`endif

    always_comb begin
        key_d = key_q;
        din_d = din_q;
        iv_d  = iv_q;
`ifdef AES_CBC_EN
        if (fsm_q == FINISH) iv_d = din_lat_q;
`endif
        // Applied after chaining so a software IV write in the FINISH cycle wins
        if (wr_en) begin
            if (key_hit) key_d[{~widx, 5'd0} +: 32] = bus.vpwdata;
            if (din_hit) din_d[{~widx, 5'd0} +: 32] = bus.vpwdata;
            if (iv_hit)  iv_d[{~widx, 5'd0} +: 32]  = bus.vpwdata;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start_q) fsm_d = LOAD;
            LOAD:    fsm_d = RUN;
            RUN:     if (core_done) fsm_d = FINISH;
            FINISH:  fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    assign core_ld = fsm_q == LOAD;

    always_ff @(posedge vclk or negedge vrst) begin
        if (!vrst) begin
            fsm_q   <= IDLE;
            key_q   <= '0;
            din_q   <= '0;
            iv_q    <= '0;
            dout_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            key_q   <= key_d;
            din_q   <= din_d;
            iv_q    <= iv_d;
            start_q <= start_wr;
            // BUSY covers the whole launch so pollers never see a stale DONE
            if (start_wr) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end
            if (fsm_q == FINISH) begin
                dout_q <= plain;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    aes_dec_core u_core (
        .clk      (vclk),
        .rst_n    (vrst),
        .ld       (core_ld),
        .key      (key_q),
        .text_in  (din_q),
        .done     (core_done),
        .text_out (core_out)
    );

    always_comb begin
        rdata = 32'h0;
        if (key_hit)                rdata = word_of(key_q, widx);
        else if (din_hit)           rdata = word_of(din_q, widx);
        else if (iv_hit)            rdata = word_of(iv_q, widx);
        else if (dout_hit)          rdata = word_of(dout_q, widx);
        else if (idx == CTRL_IDX)   rdata[CTRL_START_BIT] = start_q;
        else if (idx == STAT_IDX) begin
            rdata[STAT_DONE_BIT] = done_q;
            rdata[STAT_BUSY_BIT] = busy_q;
        end
    end

    assign bus.vprdata      = rdata;
    assign text_out_decrypt = dout_q;

endmodule

// File: tb/tb_aes_vlog_module.sv
// Directed bench for aes_vlog_module: FIPS-197 decryption, CBC/ECB chaining, busy handling,
// unmapped accesses and asynchronous reset mid-operation.
module tb_aes_vlog_module;
    import aes_vlog_pkg::*;

    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CBC2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
`ifdef AES_CBC_EN
    localparam logic [127:0] EXP_BLK2 = CBC2;
    localparam logic [127:0] EXP_IV   = CT;
`else
    localparam logic [127:0] EXP_BLK2 = PT;
    localparam logic [127:0] EXP_IV   = 128'h0;
`endif

    logic         vclk = 1'b0;
    logic         vrst;
    logic [127:0] text_out_decrypt;
    int           checks = 0;
    int           errors = 0;

    aes_vlog_if bus ();

    aes_vlog_module dut (
        .vclk             (vclk),
        .vrst             (vrst),
        .bus              (bus),
        .text_out_decrypt (text_out_decrypt)
    );

    always #5 vclk = ~vclk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] idx, input logic [31:0] data);
        @(negedge vclk);
        bus.vpsel    = 8'h01;
        bus.vpaddr   = {24'h0, idx, 2'b00};
        bus.vpwrite  = 1'b1;
        bus.vpenable = 1'b1;
        bus.vpwdata  = data;
        @(negedge vclk);
        bus.vpsel    = 8'h00;
        bus.vpwrite  = 1'b0;
        bus.vpenable = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] idx, output logic [31:0] data);
        @(negedge vclk);
        bus.vpaddr   = {24'h0, idx, 2'b00};
        bus.vpwrite  = 1'b0;
        bus.vpenable = 1'b0;
        #1 data = bus.vprdata;
    endtask

    task automatic write128(input logic [5:0] base, input logic [127:0] val);
        for (int w = 0; w < 4; w++) bus_write(6'(base + 6'(w)), val[127 - 32 * w -: 32]);
    endtask

    task automatic read128(input logic [5:0] base, output logic [127:0] val);
        logic [31:0] d;
        val = '0;
        for (int w = 0; w < 4; w++) begin
            bus_read(6'(base + 6'(w)), d);
            val[127 - 32 * w -: 32] = d;
        end
    endtask

    // Polls STATUS for DONE within the latency bound; a timeout shows up as a failed check
    task automatic wait_done(input string tag);
        logic [31:0] st;
        int          n;
        n = 0;
        bus_read(STAT_IDX, st);
        while (st[STAT_DONE_BIT] !== 1'b1 && n < int'(CORE_MAX_LAT) + 3) begin
            bus_read(STAT_IDX, st);
            n++;
        end
        check_eq({tag, "_status_done"}, 128'(st), 128'h1);
    endtask

    task automatic start_block(input string tag);
        logic [31:0] st;
        bus_write(CTRL_IDX, 32'h2);
        bus_read(STAT_IDX, st);
        check_eq({tag, "_status_busy"}, 128'(st), 128'h2);
    endtask

    initial begin
        logic [127:0] v;
        logic [31:0]  d;
        bus.vpsel    = 8'h00;
        bus.vpenable = 1'b0;
        bus.vpaddr   = 32'h0;
        bus.vpwrite  = 1'b0;
        bus.vpwdata  = 32'h0;
        vrst         = 1'b0;
        repeat (3) @(negedge vclk);
        vrst = 1'b1;

        bus_read(STAT_IDX, d);
        check_eq("reset_status", 128'(d), 128'h0);
        read128(DOUT_IDX, v);
        check_eq("reset_dout", v, 128'h0);
        check_eq("reset_text_out", text_out_decrypt, 128'h0);
        read128(KEY_IDX, v);
        check_eq("reset_key", v, 128'h0);

        write128(KEY_IDX, KEY);
        write128(DIN_IDX, CT);
        write128(IV_IDX, 128'h0);
        read128(KEY_IDX, v);
        check_eq("key_readback", v, KEY);
        read128(DIN_IDX, v);
        check_eq("din_readback", v, CT);

        start_block("blk1");
        wait_done("blk1");
        read128(DOUT_IDX, v);
        check_eq("blk1_dout", v, PT);
        check_eq("blk1_text_out", text_out_decrypt, PT);
        read128(IV_IDX, v);
        check_eq("blk1_iv", v, EXP_IV);
        bus_read(CTRL_IDX, d);
        check_eq("ctrl_self_clear", 128'(d), 128'h0);

        start_block("blk2");
        wait_done("blk2");
        read128(DOUT_IDX, v);
        check_eq("blk2_dout", v, EXP_BLK2);
        check_eq("blk2_text_out", text_out_decrypt, EXP_BLK2);
        read128(IV_IDX, v);
        check_eq("blk2_iv", v, EXP_IV);

        // Second START and a KEY write while busy must not disturb the running block
        start_block("blk3");
        bus_write(CTRL_IDX, 32'h2);
        bus_write(KEY_IDX, 32'hdeadbeef);
        wait_done("blk3");
        read128(DOUT_IDX, v);
        check_eq("blk3_dout", v, EXP_BLK2);
        repeat (CORE_MAX_LAT) @(negedge vclk);
        bus_read(STAT_IDX, d);
        check_eq("blk3_no_restart", 128'(d), 128'h1);
        bus_read(KEY_IDX, d);
        check_eq("blk3_key_stored", 128'(d), 128'hdeadbeef);
        bus_write(KEY_IDX, KEY[127:96]);

        bus_read(6'h00, d);
        check_eq("unmapped_rd_00", 128'(d), 128'h0);
        bus_read(6'h3F, d);
        check_eq("unmapped_rd_3f", 128'(d), 128'h0);
        bus_write(6'h00, 32'hffffffff);
        bus_write(6'h3F, 32'hffffffff);
        bus_write(6'h08, 32'hffffffff);
        bus_write(6'h22, 32'hffffffff);
        bus_write(DOUT_IDX, 32'h12345678);
        bus_write(STAT_IDX, 32'h0);
        read128(KEY_IDX, v);
        check_eq("unmapped_wr_key", v, KEY);
        read128(DIN_IDX, v);
        check_eq("unmapped_wr_din", v, CT);
        read128(IV_IDX, v);
        check_eq("unmapped_wr_iv", v, EXP_IV);
        read128(DOUT_IDX, v);
        check_eq("ro_dout_write", v, EXP_BLK2);
        bus_read(STAT_IDX, d);
        check_eq("ro_status_write", 128'(d), 128'h1);

        start_block("blk4");
        repeat (5) @(negedge vclk);
        #2 vrst = 1'b0;
        #1;
        check_eq("rst_text_out_async", text_out_decrypt, 128'h0);
        bus_read(STAT_IDX, d);
        check_eq("rst_status", 128'(d), 128'h0);
        read128(DOUT_IDX, v);
        check_eq("rst_dout", v, 128'h0);
        vrst = 1'b1;
        repeat (CORE_MAX_LAT) @(negedge vclk);
        bus_read(STAT_IDX, d);
        check_eq("post_rst_status", 128'(d), 128'h0);
        check_eq("post_rst_text_out", text_out_decrypt, 128'h0);
        read128(KEY_IDX, v);
        check_eq("post_rst_key", v, 128'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
